// File: rtl/i2c_target.sv
// I2C target responder at a fixed 7-bit address.
// SCL/SDA are oversampled on clk through a synchronizer and a glitch filter.
// The SDA pad is open-drain: sda_oe=1 pulls the line low. There is no clock stretching.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h3c,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_low,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam int unsigned CNT_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned BCNT_W = 4;
  localparam int unsigned LINE_SCL = 0;
  localparam int unsigned LINE_SDA = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  // Progress inside a 9th (ACK) clock: wait for the fall that starts it,
  // wait for its rise, then wait for the fall that ends it.
  typedef enum logic [1:0] {
    PH_WAIT_FALL = 2'd0,
    PH_WAIT_RISE = 2'd1,
    PH_WAIT_END  = 2'd2
  } phase_e;

  // Input conditioning: index 0 is SCL, index 1 is SDA.
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            filt_q;
  logic [1:0]            filt_prev_q;
  logic [1:0][CNT_W-1:0] fcnt_q;

  // Protocol state.
  state_e            state_q,    state_d;
  phase_e            phase_q,    phase_d;
  logic [BCNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0]        shift_q,    shift_d;
  logic              rw_q,       rw_d;
  logic              first_q,    first_d;
  logic              oe_q,       oe_d;
  logic [7:0]        rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_first_q, rx_first_d;
  logic              tx_req_q,   tx_req_d;
  logic              busy_q,     busy_d;

  // Edge and bus-condition strobes derived from the filtered lines.
  logic       scl_f;
  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] in_byte;
  logic       addr_hit;

  // Two-flop synchronizer followed by a level filter needing FILT_LEN equal samples.
  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      fcnt_q      <= '0;
    end else begin
      sync1_q     <= {sda_in, scl_in};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl_f     = filt_q[LINE_SCL];
  assign sda_f     = filt_q[LINE_SDA];
  assign scl_rise  = scl_f & ~filt_prev_q[LINE_SCL];
  assign scl_fall  = ~scl_f & filt_prev_q[LINE_SCL];
  assign start_det = scl_f & filt_prev_q[LINE_SCL] & filt_prev_q[LINE_SDA] & ~sda_f;
  assign stop_det  = scl_f & filt_prev_q[LINE_SCL] & ~filt_prev_q[LINE_SDA] & sda_f;
  assign in_byte   = {shift_q[6:0], sda_f};
  // General call (address 0) is never acknowledged.
  assign addr_hit  = (in_byte[7:1] == TARGET_ADDR) && (in_byte[7:1] != 7'd0);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_WAIT_FALL;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output logic; START/STOP override every state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    first_d    = first_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      phase_d   = PH_WAIT_FALL;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      phase_d   = PH_WAIT_FALL;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = in_byte;
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(7)) begin
              bit_cnt_d = '0;
              phase_d   = PH_WAIT_FALL;
              if (addr_hit) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = in_byte[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_WR_ACK: begin
          case (phase_q)
            PH_WAIT_FALL: begin
              if (scl_fall) begin
                oe_d    = 1'b1;
                phase_d = PH_WAIT_RISE;
              end
            end
            PH_WAIT_RISE: begin
              if (scl_rise) begin
                phase_d = PH_WAIT_END;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  tx_req_d = 1'b1;
                end
              end
            end
            default: begin
              if (scl_fall) begin
                phase_d   = PH_WAIT_FALL;
                bit_cnt_d = '0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  // First read byte: load and drive its MSB on this fall.
                  shift_d = tx_data;
                  oe_d    = ~tx_data[7];
                  state_d = ST_RD_DATA;
                end else begin
                  oe_d    = 1'b0;
                  state_d = ST_WR_DATA;
                  if (state_q == ST_ADDR_ACK) begin
                    first_d = 1'b1;
                  end
                end
              end
            end
          endcase
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = in_byte;
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(7)) begin
              bit_cnt_d  = '0;
              rx_data_d  = in_byte;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              phase_d    = PH_WAIT_FALL;
              state_d    = ST_WR_ACK;
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == BCNT_W'(8)) begin
              // All 8 bits clocked out: release for the master's ACK bit.
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              phase_d   = PH_WAIT_RISE;
              state_d   = ST_RD_ACK;
            end else begin
              oe_d    = ~shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end

        ST_RD_ACK: begin
          if (phase_q == PH_WAIT_RISE) begin
            if (scl_rise) begin
              if (!sda_f) begin
                tx_req_d = 1'b1;
                phase_d  = PH_WAIT_END;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end else if (scl_fall) begin
            shift_d   = tx_data;
            oe_d      = ~tx_data[7];
            bit_cnt_d = '0;
            phase_d   = PH_WAIT_FALL;
            state_d   = ST_RD_DATA;
          end
        end

        ST_IGNORE: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged bus master plus an output monitor.
module tb_i2c_target;

  localparam int Q = 10;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst_low;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       sda_line;

  int checks   = 0;
  int failures = 0;

  // Monitor-owned records.
  logic [8:0] rx_log [64];
  int         rx_n   = 0;
  int         tx_n   = 0;
  int         viol_n = 0;
  logic [7:0] scl_hist = 8'h00;
  logic       oe_prev  = 1'b0;
  logic       rst_prev = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target dut (
    .clk      (clk),
    .rst_low  (rst_low),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Log output pulses and flag any SDA drive change while SCL is settled high.
  always @(negedge clk) begin
    if (rx_valid && rx_n < 64) begin
      rx_log[rx_n] = {rx_first, rx_data};
      rx_n = rx_n + 1;
    end
    if (tx_req) tx_n = tx_n + 1;
    if (rst_low && rst_prev && (sda_oe !== oe_prev) && (scl_hist == 8'hFF))
      viol_n = viol_n + 1;
    scl_hist = {scl_hist[6:0], scl_m};
    oe_prev  = sda_oe;
    rst_prev = rst_low;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  // One SCL period; optionally a 2-clk SCL glitch while SCL is low.
  task automatic bit_xfer(input logic b, input logic glitch, output logic r);
    sda_m = b;
    if (glitch) begin
      wait_clk(3); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q - 5);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b1; wait_clk(Q);
    r = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  // Returns the line level seen on the 9th clock (0 = ACK).
  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack_line);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], (i == glitch_bit), r);
    bit_xfer(1'b1, 1'b0, ack_line);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, r);
      d[i] = r;
    end
    tx_data = next_tx;
    bit_xfer(nack, 1'b0, r);
  endtask

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_line9;
    logic       exp_rx;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic       a;
    logic [7:0] d;
    int         rx0;
    int         tx0;

    vecs[0] = '{addr: 7'h3c, data: 8'h00, exp_line9: 1'b0, exp_rx: 1'b1, exp_busy: 1'b1};
    vecs[1] = '{addr: 7'h3d, data: 8'h5a, exp_line9: 1'b1, exp_rx: 1'b0, exp_busy: 1'b0};
    vecs[2] = '{addr: 7'h00, data: 8'h11, exp_line9: 1'b1, exp_rx: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{addr: 7'h1e, data: 8'h3c, exp_line9: 1'b1, exp_rx: 1'b0, exp_busy: 1'b0};
    vecs[4] = '{addr: 7'h3c, data: 8'hff, exp_line9: 1'b0, exp_rx: 1'b1, exp_busy: 1'b1};
    vecs[5] = '{addr: 7'h3c, data: 8'h81, exp_line9: 1'b0, exp_rx: 1'b1, exp_busy: 1'b1};
    vecs[6] = '{addr: 7'h7c, data: 8'h42, exp_line9: 1'b1, exp_rx: 1'b0, exp_busy: 1'b0};

    rst_low = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    wait_clk(5);
    check("rst_sda_oe",   32'(sda_oe),   32'h0);
    check("rst_rx_data",  32'(rx_data),  32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_first", 32'(rx_first), 32'h0);
    check("rst_tx_req",   32'(tx_req),   32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    rst_low = 1'b1;
    wait_clk(20);

    // Single-byte write frames: address match, mismatch, general call.
    for (int v = 0; v < 7; v++) begin
      rx0 = rx_n; tx0 = tx_n;
      bus_start();
      write_byte({vecs[v].addr, 1'b0}, -1, a);
      check($sformatf("v%0d_addr_ack", v), 32'(a), 32'(vecs[v].exp_line9));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      write_byte(vecs[v].data, -1, a);
      check($sformatf("v%0d_data_ack", v), 32'(a), 32'(vecs[v].exp_line9));
      bus_stop();
      wait_clk(10);
      check($sformatf("v%0d_rx_cnt", v), 32'(rx_n - rx0), 32'(vecs[v].exp_rx));
      if (vecs[v].exp_rx)
        check($sformatf("v%0d_rx", v), 32'(rx_log[rx0]), {23'd0, 1'b1, vecs[v].data});
      check($sformatf("v%0d_busy_stop", v), 32'(busy), 32'h0);
      check($sformatf("v%0d_tx_req", v), 32'(tx_n - tx0), 32'h0);
    end

    // Two-byte write: rx_first only on the first byte.
    rx0 = rx_n;
    bus_start();
    write_byte(8'h78, -1, a); check("w2_addr_ack", 32'(a), 32'h0);
    write_byte(8'h00, -1, a); check("w2_d0_ack",   32'(a), 32'h0);
    write_byte(8'ha5, -1, a); check("w2_d1_ack",   32'(a), 32'h0);
    check("w2_busy", 32'(busy), 32'h1);
    bus_stop(); wait_clk(10);
    check("w2_rx_cnt",    32'(rx_n - rx0),     32'h2);
    check("w2_rx0",       32'(rx_log[rx0]),    32'h100);
    check("w2_rx1",       32'(rx_log[rx0 + 1]), 32'h0a5);
    check("w2_busy_stop", 32'(busy),           32'h0);

    // Read two bytes: ACK the first, NACK the second.
    rx0 = rx_n; tx0 = tx_n; tx_data = 8'h5a;
    bus_start();
    write_byte(8'h79, -1, a); check("rd_addr_ack", 32'(a), 32'h0);
    read_byte(1'b0, 8'hc3, d); check("rd_byte0", 32'(d), 32'h5a);
    read_byte(1'b1, 8'h00, d); check("rd_byte1", 32'(d), 32'hc3);
    check("rd_released", 32'(sda_oe), 32'h0);
    bus_stop(); wait_clk(10);
    check("rd_tx_req", 32'(tx_n - tx0), 32'h2);
    check("rd_rx_cnt", 32'(rx_n - rx0), 32'h0);

    // Write, repeated START, read one byte, then a fresh write.
    rx0 = rx_n; tx0 = tx_n; tx_data = 8'h96;
    bus_start();
    write_byte(8'h78, -1, a); check("rs_addr_ack", 32'(a), 32'h0);
    write_byte(8'h10, -1, a); check("rs_d_ack",    32'(a), 32'h0);
    bus_rstart();
    check("rs_busy_cleared", 32'(busy), 32'h0);
    write_byte(8'h79, -1, a); check("rs_raddr_ack", 32'(a), 32'h0);
    read_byte(1'b1, 8'h00, d); check("rs_rd", 32'(d), 32'h96);
    bus_stop(); wait_clk(10);
    check("rs_rx_cnt", 32'(rx_n - rx0), 32'h1);
    check("rs_rx0",    32'(rx_log[rx0]), 32'h110);
    check("rs_tx_req", 32'(tx_n - tx0), 32'h1);
    rx0 = rx_n;
    bus_start();
    write_byte(8'h78, -1, a);
    write_byte(8'h22, -1, a);
    bus_stop(); wait_clk(10);
    check("rs_first_again", 32'(rx_log[rx0]), 32'h122);

    // 2-clk SCL glitch during a data byte must be filtered out.
    rx0 = rx_n;
    bus_start();
    write_byte(8'h78, -1, a);
    write_byte(8'hb4, 3, a); check("gl_ack", 32'(a), 32'h0);
    bus_stop(); wait_clk(10);
    check("gl_rx_cnt", 32'(rx_n - rx0), 32'h1);
    check("gl_rx",     32'(rx_log[rx0]), 32'h1b4);

    // Asynchronous reset while the target drives ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h78;
      bit_xfer(ab[i], 1'b0, a);
    end
    sda_m = 1'b1;
    check("ar_driving", 32'(sda_oe), 32'h1);
    rst_low = 1'b0;
    #1;
    check("ar_released", 32'(sda_oe), 32'h0);
    check("ar_busy",     32'(busy),   32'h0);
    wait_clk(3);
    rst_low = 1'b1;
    scl_m = 1'b1; wait_clk(40);
    rx0 = rx_n;
    bus_start();
    write_byte(8'h78, -1, a); check("ar_addr_ack", 32'(a), 32'h0);
    write_byte(8'h5c, -1, a); check("ar_d_ack",    32'(a), 32'h0);
    bus_stop(); wait_clk(10);
    check("ar_rx", 32'(rx_log[rx0]), 32'h15c);

    check("oe_stable_scl_high", 32'(viol_n), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
